// File: rtl/mem_load_sequencer_if.sv
// Write-request bundle for the program loader: two requester ports in, one memory write port out.
interface mem_load_sequencer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              m0_valid;
    logic              m0_ready;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_data;

    logic              m1_valid;
    logic              m1_ready;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_data;

    logic              axi_mem_w;
    logic [ADDR_W-1:0] axi_mem_addr;
    logic [DATA_W-1:0] axi_mem_data;

    modport master (
        output m0_valid, m0_addr, m0_data,
        output m1_valid, m1_addr, m1_data,
        input  m0_ready, m1_ready,
        input  axi_mem_w, axi_mem_addr, axi_mem_data
    );

    modport slave (
        input  m0_valid, m0_addr, m0_data,
        input  m1_valid, m1_addr, m1_data,
        output m0_ready, m1_ready,
        output axi_mem_w, axi_mem_addr, axi_mem_data
    );
endinterface

// File: rtl/mem_load_sequencer.sv
// Round-robin arbitrates two loaders onto the memory write port and gates CPU reset around loading.
// Latency: one cycle from handshake to memory write strobe; one write per cycle.
// Backpressure: ready is low outside LOAD; unaccepted requests must be held by the requester.
module mem_load_sequencer #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             nreset,
    mem_load_sequencer_if.slave bus,
    input  logic             run_req,
    input  logic             halt_req,
    output logic             cpu_nreset,
    output logic [CNT_W-1:0] wr_count,
    output logic             busy
);
    typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_t;

    localparam int unsigned      CNT_MAX_I = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_MAX_I[CNT_W-1:0];

    state_t            state;
    logic              prio_m1;
    logic              grant0;
    logic              grant1;
    logic              mem_w;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    // Ready is gated by nreset so neither port sees a grant while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == LOAD && nreset) begin
            if (bus.m0_valid && (!bus.m1_valid || !prio_m1)) begin
                grant0 = 1'b1;
            end else if (bus.m1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign bus.m0_ready     = grant0;
    assign bus.m1_ready     = grant1;
    assign bus.axi_mem_w    = mem_w;
    assign bus.axi_mem_addr = mem_addr;
    assign bus.axi_mem_data = mem_data;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= LOAD;
            prio_m1    <= 1'b0;
            mem_w      <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_nreset <= 1'b0;
            wr_count   <= '0;
            busy       <= 1'b1;
        end else begin
            mem_w <= grant0 | grant1;
            if (grant0) begin
                mem_addr <= bus.m0_addr;
                mem_data <= bus.m0_data;
                prio_m1  <= 1'b1;
            end else if (grant1) begin
                mem_addr <= bus.m1_addr;
                mem_data <= bus.m1_data;
                prio_m1  <= 1'b0;
            end
            if ((grant0 | grant1) && wr_count != CNT_MAX) begin
                wr_count <= wr_count + CNT_W'(1);
            end

            case (state)
                LOAD: begin
                    if (run_req) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
                RUN: begin
                    // CPU is released one cycle after entering RUN, after the drained write.
                    if (halt_req) begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        cpu_nreset <= 1'b0;
                        wr_count   <= '0;
                    end else begin
                        cpu_nreset <= 1'b1;
                    end
                end
                default: begin
                    state <= LOAD;
                    busy  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_load_sequencer.sv
// Bench for mem_load_sequencer: directed literal checks plus randomized traffic against a behavioural model.
module tb_mem_load_sequencer;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 10;

    logic             clk = 1'b0;
    logic             nreset;
    logic             run_req;
    logic             halt_req;
    logic             cpu_nreset;
    logic [CNT_W-1:0] wr_count;
    logic             busy;

    mem_load_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_load_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .bus        (bus.slave),
        .run_req    (run_req),
        .halt_req   (halt_req),
        .cpu_nreset (cpu_nreset),
        .wr_count   (wr_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase flags, who was served last, last written word, writes since load.
    bit                m_loading = 1'b1;
    bit                m_drain   = 1'b0;
    bit                m_running = 1'b0;
    bit                m_cpu     = 1'b0;
    bit                m_w       = 1'b0;
    int                m_last    = 1;
    logic [ADDR_W-1:0] m_addr    = '0;
    logic [DATA_W-1:0] m_data    = '0;
    int                m_cnt     = 0;

    // 0 = no grant, 1 = m0, 2 = m1
    function automatic int exp_grant();
        if (!nreset || !m_loading) return 0;
        if (bus.m0_valid && bus.m1_valid) return (m_last == 0) ? 2 : 1;
        if (bus.m0_valid) return 1;
        if (bus.m1_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge nreset) begin : model
        int g;
        if (!nreset) begin
            m_loading <= 1'b1;
            m_drain   <= 1'b0;
            m_running <= 1'b0;
            m_cpu     <= 1'b0;
            m_w       <= 1'b0;
            m_last    <= 1;
            m_addr    <= '0;
            m_data    <= '0;
            m_cnt     <= 0;
        end else begin
            g = exp_grant();
            m_w <= (g != 0);
            if (g == 1) begin
                m_addr <= bus.m0_addr;
                m_data <= bus.m0_data;
                m_last <= 0;
            end else if (g == 2) begin
                m_addr <= bus.m1_addr;
                m_data <= bus.m1_data;
                m_last <= 1;
            end
            if (g != 0) m_cnt <= (m_cnt + 1 > 512) ? 512 : m_cnt + 1;
            if (m_loading && run_req) begin
                m_loading <= 1'b0;
                m_drain   <= 1'b1;
            end
            if (m_drain) begin
                m_drain   <= 1'b0;
                m_running <= 1'b1;
            end
            if (m_running) begin
                if (halt_req) begin
                    m_running <= 1'b0;
                    m_loading <= 1'b1;
                    m_cpu     <= 1'b0;
                    m_cnt     <= 0;
                end else begin
                    m_cpu <= 1'b1;
                end
            end
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin : compare
        int g;
        if (chk_en) begin
            g = exp_grant();
            chk("m0_ready",     64'(bus.m0_ready),     64'(g == 1));
            chk("m1_ready",     64'(bus.m1_ready),     64'(g == 2));
            chk("axi_mem_w",    64'(bus.axi_mem_w),    64'(m_w));
            chk("axi_mem_addr", 64'(bus.axi_mem_addr), 64'(m_addr));
            chk("axi_mem_data", 64'(bus.axi_mem_data), 64'(m_data));
            chk("cpu_nreset",   64'(cpu_nreset),       64'(m_cpu));
            chk("wr_count",     64'(wr_count),         64'(m_cnt));
            chk("busy",         64'(busy),             64'(!m_running));
        end
    end

    logic acc0 = 1'b0;
    logic acc1 = 1'b0;

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        acc0 = bus.m0_valid & bus.m0_ready;
        acc1 = bus.m1_valid & bus.m1_ready;
        @(posedge clk);
        #1;
        run_req  = 1'b0;
        halt_req = 1'b0;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    logic [ADDR_W-1:0] arb_exp [4];
    int i0;
    int i1;

    initial begin
        arb_exp = '{9'h010, 9'h100, 9'h011, 9'h101};
        bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_data = '0;
        bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_data = '0;
        run_req = 1'b0; halt_req = 1'b0;
        nreset = 1'b1;
        #1 nreset = 1'b0;
        bus.m0_valid = 1'b1;
        #1;
        chk_en = 1'b1;
        chk("rst_m0_ready", 64'(bus.m0_ready), 64'd0);
        chk("rst_cpu_nreset", 64'(cpu_nreset), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_axi_mem_w", 64'(bus.axi_mem_w), 64'd0);
        bus.m0_valid = 1'b0;
        @(posedge clk);
        #1 nreset = 1'b1;

        // Single m0 write
        bus.m0_valid = 1'b1; bus.m0_addr = 9'h005; bus.m0_data = 32'hDEADBEEF;
        #1 chk("w1_m0_ready", 64'(bus.m0_ready), 64'd1);
        tick();
        bus.m0_valid = 1'b0;
        chk("w1_axi_w", 64'(bus.axi_mem_w), 64'd1);
        chk("w1_addr", 64'(bus.axi_mem_addr), 64'h005);
        chk("w1_data", 64'(bus.axi_mem_data), 64'hDEADBEEF);
        chk("w1_wr_count", 64'(wr_count), 64'd1);
        chk("w1_cpu_nreset", 64'(cpu_nreset), 64'd0);

        // Round-robin with both ports valid, from a fresh pointer
        do_reset();
        i0 = 0; i1 = 0;
        for (int k = 0; k < 4; k++) begin
            bus.m0_valid = 1'b1; bus.m0_addr = 9'(9'h010 + i0); bus.m0_data = 32'(32'hA000 + i0);
            bus.m1_valid = 1'b1; bus.m1_addr = 9'(9'h100 + i1); bus.m1_data = 32'(32'hB000 + i1);
            tick();
            chk("arb_w", 64'(bus.axi_mem_w), 64'd1);
            chk("arb_addr", 64'(bus.axi_mem_addr), 64'(arb_exp[k]));
            if (acc0) i0++;
            if (acc1) i1++;
        end
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;

        // run_req coinciding with an m1 handshake
        bus.m1_valid = 1'b1; bus.m1_addr = 9'h1FF; bus.m1_data = 32'h12345678;
        run_req = 1'b1;
        #1 chk("run_m1_ready", 64'(bus.m1_ready), 64'd1);
        tick();
        chk("drain_w", 64'(bus.axi_mem_w), 64'd1);
        chk("drain_addr", 64'(bus.axi_mem_addr), 64'h1FF);
        chk("drain_data", 64'(bus.axi_mem_data), 64'h12345678);
        chk("drain_cpu", 64'(cpu_nreset), 64'd0);
        bus.m0_valid = 1'b1; bus.m0_addr = 9'h0AA; bus.m0_data = 32'hCAFEF00D;
        #1 chk("drain_readys", 64'({bus.m0_ready, bus.m1_ready}), 64'd0);
        tick();
        chk("run1_w", 64'(bus.axi_mem_w), 64'd0);
        chk("run1_cpu", 64'(cpu_nreset), 64'd0);
        chk("run1_busy", 64'(busy), 64'd0);
        chk("run1_readys", 64'({bus.m0_ready, bus.m1_ready}), 64'd0);
        tick();
        chk("run2_cpu", 64'(cpu_nreset), 64'd1);
        chk("run2_readys", 64'({bus.m0_ready, bus.m1_ready}), 64'd0);

        // Halt back to LOAD; m0 served next since m1 was last
        halt_req = 1'b1;
        tick();
        chk("halt_cpu", 64'(cpu_nreset), 64'd0);
        chk("halt_wr_count", 64'(wr_count), 64'd0);
        chk("halt_busy", 64'(busy), 64'd1);
        chk("halt_m0_ready", 64'(bus.m0_ready), 64'd1);
        tick();
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        chk("halt_w", 64'(bus.axi_mem_w), 64'd1);
        chk("halt_addr", 64'(bus.axi_mem_addr), 64'h0AA);

        // Counter saturation and address wrap pass-through
        do_reset();
        bus.m0_valid = 1'b1;
        for (int i = 0; i < 520; i++) begin
            bus.m0_addr = 9'(i);
            bus.m0_data = $urandom;
            tick();
            if (i == 511) chk("sat_addr_1ff", 64'(bus.axi_mem_addr), 64'h1FF);
            if (i == 512) chk("sat_addr_000", 64'(bus.axi_mem_addr), 64'h000);
        end
        chk("sat_wr_count", 64'(wr_count), 64'd512);

        // Asynchronous reset while a strobe is in flight
        chk("pre_rst_w", 64'(bus.axi_mem_w), 64'd1);
        nreset = 1'b0;
        #1;
        chk("arst_w", 64'(bus.axi_mem_w), 64'd0);
        chk("arst_addr", 64'(bus.axi_mem_addr), 64'd0);
        chk("arst_data", 64'(bus.axi_mem_data), 64'd0);
        chk("arst_wr_count", 64'(wr_count), 64'd0);
        chk("arst_m0_ready", 64'(bus.m0_ready), 64'd0);
        @(posedge clk);
        #1 nreset = 1'b1;
        bus.m1_valid = 1'b1; bus.m1_addr = 9'h033; bus.m1_data = 32'h33;
        #1;
        chk("arst_first_m0", 64'(bus.m0_ready), 64'd1);
        chk("arst_first_m1", 64'(bus.m1_ready), 64'd0);
        tick();
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;

        // Randomized traffic, run/halt pulses and occasional resets
        for (int c = 0; c < 3000; c++) begin
            if (acc0 || !bus.m0_valid) begin
                bus.m0_valid = 1'($urandom_range(0, 1));
                bus.m0_addr  = 9'($urandom);
                bus.m0_data  = $urandom;
            end
            if (acc1 || !bus.m1_valid) begin
                bus.m1_valid = 1'($urandom_range(0, 1));
                bus.m1_addr  = 9'($urandom);
                bus.m1_data  = $urandom;
            end
            run_req  = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 499) == 0) begin
                acc0 = 1'b0;
                acc1 = 1'b0;
                do_reset();
            end else begin
                tick();
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
